// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : Instruction prefetcher with a DEPTH-entry byte FIFO and jump flush.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] memAddr,
    output logic       memReq,
    input  logic       memAck,
    input  logic [7:0] memData,
    output logic [7:0] instr,
    output logic [7:0] instrPC,
    output logic       instrValid,
    input  logic       instrTake,
    input  logic       jump,
    input  logic [7:0] jumpAddr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       fetchPC_q, fetchPC_d;
    logic [7:0]       memAddr_q, memAddr_d;
    logic             memReq_q, memReq_d;

    logic [7:0]       fifoData_q [DEPTH];
    logic [7:0]       fifoPC_q   [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, wrPtr_q;
    logic [PTR_W:0]   count_q;

    logic             push;
    logic             flush;
    logic             pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            fetchPC_q <= 8'h00;
            memAddr_q <= 8'h00;
            memReq_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fetchPC_q <= fetchPC_d;
            memAddr_q <= memAddr_d;
            memReq_q  <= memReq_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fetchPC_d = fetchPC_q;
        memAddr_d = memAddr_q;
        memReq_d  = memReq_q;
        push      = 1'b0;
        flush     = 1'b0;
        case (state_q)
            IDLE: begin
                if (jump) begin
                    state_d   = WAIT;
                    memReq_d  = 1'b1;
                    memAddr_d = jumpAddr;
                    fetchPC_d = jumpAddr;
                    flush     = 1'b1;
                end else if (count_q < FULL_COUNT) begin
                    state_d   = WAIT;
                    memReq_d  = 1'b1;
                    memAddr_d = fetchPC_q;
                end else begin
                    memReq_d  = 1'b0;
                end
            end
            WAIT: begin
                if (jump) begin
                    // The in-flight byte belongs to the old stream; drop it.
                    flush     = 1'b1;
                    fetchPC_d = jumpAddr;
                    if (memAck) begin
                        state_d  = IDLE;
                        memReq_d = 1'b0;
                    end else begin
                        state_d  = DISCARD;
                    end
                end else if (memAck) begin
                    push      = 1'b1;
                    fetchPC_d = fetchPC_q + 8'd1;
                    state_d   = IDLE;
                    memReq_d  = 1'b0;
                end
            end
            DISCARD: begin
                if (jump) begin
                    fetchPC_d = jumpAddr;
                end
                if (memAck) begin
                    state_d  = IDLE;
                    memReq_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                memReq_d = 1'b0;
            end
        endcase
    end

    // A flush on jump takes priority over a simultaneous consumer pop.
    assign pop = instrTake && (count_q != '0) && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoData_q[wrPtr_q] <= memData;
            fifoPC_q[wrPtr_q]   <= memAddr_q;
        end
    end

    assign memReq     = memReq_q;
    assign memAddr    = memAddr_q;
    assign instrValid = (count_q != '0);
    assign instr      = instrValid ? fifoData_q[rdPtr_q] : 8'h00;
    assign instrPC    = instrValid ? fifoPC_q[rdPtr_q]   : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Directed self-checking bench for fetch_unit (DEPTH = 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] memAddr;
    logic       memReq;
    logic       memAck;
    logic [7:0] memData;
    logic [7:0] instr;
    logic [7:0] instrPC;
    logic       instrValid;
    logic       instrTake = 1'b0;
    logic       jump      = 1'b0;
    logic [7:0] jumpAddr  = 8'h00;

    int         nVec = 0;
    int         nErr = 0;

    // Memory model: byte at address A is A ^ 0x55; ack after memLat cycles of memReq.
    logic       autoMem  = 1'b1;
    logic       autoAck  = 1'b0;
    logic       manAck   = 1'b0;
    int         memLat   = 1;
    int         waitCnt  = 0;
    logic [7:0] firstAddr = 8'h00;
    logic [7:0] reqLog [$];

    assign memAck  = autoMem ? autoAck : manAck;
    assign memData = memAddr ^ 8'h55;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .memAddr    (memAddr),
        .memReq     (memReq),
        .memAck     (memAck),
        .memData    (memData),
        .instr      (instr),
        .instrPC    (instrPC),
        .instrValid (instrValid),
        .instrTake  (instrTake),
        .jump       (jump),
        .jumpAddr   (jumpAddr)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst || !memReq) begin
            waitCnt = 0;
            autoAck = 1'b0;
        end else begin
            waitCnt++;
            if (waitCnt == 1) begin
                firstAddr = memAddr;
                reqLog.push_back(memAddr);
            end
            autoAck = (waitCnt >= memLat);
            if (autoMem && autoAck) begin
                check_vec("addr_hold", memAddr, firstAddr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves rst asserted; the caller releases it together with any first-cycle inputs.
    task automatic do_reset();
        rst       = 1'b1;
        jump      = 1'b0;
        instrTake = 1'b0;
        manAck    = 1'b0;
        autoMem   = 1'b1;
        memLat    = 1;
        ticks(2);
        reqLog.delete();
        check_vec("rst_memReq", memReq, 1'b0);
        check_vec("rst_memAddr", memAddr, 8'h00);
        check_vec("rst_valid", instrValid, 1'b0);
        check_vec("rst_instr", instr, 8'h00);
        check_vec("rst_instrPC", instrPC, 8'h00);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!instrValid && n < 50) begin
            tick();
            n++;
        end
        if (!instrValid) check_vec("valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] pc);
        wait_valid();
        check_vec({tag, "_pc"}, instrPC, pc);
        check_vec({tag, "_instr"}, instr, pc ^ 8'h55);
        instrTake = 1'b1;
        tick();
        instrTake = 1'b0;
    endtask

    initial begin
        // Fill from reset, 1-cycle memory, no consumer.
        do_reset();
        rst = 1'b0;
        tick();
        check_vec("first_req", memReq, 1'b1);
        check_vec("first_addr", memAddr, 8'h00);
        check_vec("first_valid", instrValid, 1'b0);
        tick();
        check_vec("lat_valid", instrValid, 1'b1);
        check_vec("lat_instr", instr, 8'h55);
        check_vec("lat_pc", instrPC, 8'h00);
        ticks(20);
        check_vec("fill_nreq", reqLog.size(), 4);
        for (int i = 0; i < 4 && i < reqLog.size(); i++) check_vec("fill_addr", reqLog[i], i);
        check_vec("full_memReq", memReq, 1'b0);
        check_vec("full_head_pc", instrPC, 8'h00);

        // Single pop from a full FIFO releases exactly one request.
        instrTake = 1'b1;
        tick();
        instrTake = 1'b0;
        check_vec("pop_head_pc", instrPC, 8'h01);
        check_vec("pop_head_instr", instr, 8'h54);
        tick();
        check_vec("refill_req", memReq, 1'b1);
        check_vec("refill_addr", memAddr, 8'h04);
        ticks(20);
        check_vec("refill_nreq", reqLog.size(), 5);
        if (reqLog.size() >= 5) check_vec("refill_log", reqLog[4], 8'h04);
        for (int k = 1; k <= 8; k++) pop_expect("order", 8'(k));

        // Address wrap 0xFF -> 0x00.
        do_reset();
        rst      = 1'b0;
        jump     = 1'b1;
        jumpAddr = 8'hFF;
        tick();
        jump = 1'b0;
        check_vec("wrap_addr", memAddr, 8'hFF);
        pop_expect("wrap_ff", 8'hFF);
        pop_expect("wrap_00", 8'h00);
        if (reqLog.size() >= 2) check_vec("wrap_next", reqLog[1], 8'h00);
        else check_vec("wrap_nreq", reqLog.size(), 2);

        // Jump while waiting on a slow memory: DISCARD, old byte never delivered.
        do_reset();
        memLat   = 3;
        rst      = 1'b0;
        jump     = 1'b1;
        jumpAddr = 8'h05;
        tick();
        check_vec("disc_addr5", memAddr, 8'h05);
        jumpAddr = 8'h40;
        tick();
        jump = 1'b0;
        check_vec("disc_holdreq", memReq, 1'b1);
        check_vec("disc_holdaddr", memAddr, 8'h05);
        ticks(2);
        check_vec("disc_done_req", memReq, 1'b0);
        check_vec("disc_dropped", instrValid, 1'b0);
        tick();
        check_vec("disc_newreq", memReq, 1'b1);
        check_vec("disc_newaddr", memAddr, 8'h40);
        pop_expect("disc_first", 8'h40);

        // Jump, ack and take in the same cycle: no DISCARD, FIFO flushed.
        do_reset();
        autoMem = 1'b0;
        rst     = 1'b0;
        tick();
        manAck = 1'b1;
        tick();
        manAck = 1'b0;
        check_vec("jack_pre_valid", instrValid, 1'b1);
        tick();
        check_vec("jack_req1", memAddr, 8'h01);
        manAck    = 1'b1;
        jump      = 1'b1;
        jumpAddr  = 8'h80;
        instrTake = 1'b1;
        tick();
        manAck    = 1'b0;
        jump      = 1'b0;
        instrTake = 1'b0;
        check_vec("jack_memReq", memReq, 1'b0);
        check_vec("jack_flush", instrValid, 1'b0);
        check_vec("jack_instr", instr, 8'h00);
        tick();
        check_vec("jack_newreq", memReq, 1'b1);
        check_vec("jack_newaddr", memAddr, 8'h80);
        manAck = 1'b1;
        tick();
        manAck = 1'b0;
        check_vec("jack_pc", instrPC, 8'h80);
        check_vec("jack_byte", instr, 8'hD5);

        // Jump from IDLE with a non-empty FIFO flushes it.
        jump      = 1'b1;
        jumpAddr  = 8'h20;
        instrTake = 1'b1;
        tick();
        jump      = 1'b0;
        instrTake = 1'b0;
        check_vec("ijump_flush", instrValid, 1'b0);
        check_vec("ijump_addr", memAddr, 8'h20);
        check_vec("ijump_req", memReq, 1'b1);

        // Reset mid-WAIT with ack high abandons the request.
        manAck = 1'b1;
        rst    = 1'b1;
        tick();
        manAck  = 1'b0;
        autoMem = 1'b1;
        memLat  = 1;
        check_vec("rstw_memReq", memReq, 1'b0);
        check_vec("rstw_valid", instrValid, 1'b0);
        check_vec("rstw_addr", memAddr, 8'h00);
        rst       = 1'b0;
        instrTake = 1'b1;
        tick();
        instrTake = 1'b0;
        check_vec("rstw_empty_take", instrValid, 1'b0);
        check_vec("rstw_req", memReq, 1'b1);
        check_vec("rstw_req_addr", memAddr, 8'h00);
        pop_expect("rstw_first", 8'h00);
        pop_expect("rstw_second", 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
